// File: rtl/intersection_model_if.sv
// rtl/intersection_model_if.sv - car-arrival handshake bundle between a traffic source and intersection_model
// Purpose: groups the per-approach arrival handshake ([0]=N, [1]=S, [2]=E, [3]=W).
// Signals:
//   arr_valid [3:0]  car arriving on approach d
//   arr_turn  [7:0]  2-bit turn per approach at [2d+1:2d]: 00 fwd, 01 left, 10 right, 11 fwd
//   arr_ready [3:0]  approach d FIFO can accept a car
// Modports: master = car source, slave = intersection.
interface intersection_model_if;
  logic [3:0] arr_valid;
  logic [7:0] arr_turn;
  logic [3:0] arr_ready;

  modport master (output arr_valid, output arr_turn, input arr_ready);
  modport slave  (input arr_valid, input arr_turn, output arr_ready);
endinterface

// File: rtl/intersection_model.sv
// rtl/intersection_model.sv - 4-way intersection model: per-approach car FIFOs, centre-tile walk, collision flag
// Purpose: queues arriving cars per approach, releases a head car when its light permits its turn,
//   walks it across the 2x2 centre tiles (0=NW, 1=NE, 2=SW, 3=SE) and reports occupancy.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   outN/outS/outE/outW [2:0] light codes: 000 stop, 001 fwd only, 010 left only, 011 right only, 100 go, else stop
//   arr (slave)              arrival handshake (arr_valid, arr_turn, arr_ready)
//   sensor_light [7:0]       [6]=N wait, [4]=S wait, [5]=E wait, [7]=W wait, [3:0]=centre tile occupancy
//   exit_pulse [3:0]         one-cycle pulse when approach d's car leaves the centre
//   collision                sticky: two cars were on the same centre tile in the same cycle
module intersection_model #(
  parameter int QDEPTH      = 4,
  parameter int TILE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          outN,
  input  logic [2:0]          outS,
  input  logic [2:0]          outE,
  input  logic [2:0]          outW,
  intersection_model_if.slave arr,
  output logic [7:0]          sensor_light,
  output logic [3:0]          exit_pulse,
  output logic                collision
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (TILE_CYCLES > 1) ? $clog2(TILE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(QDEPTH);
  localparam logic [TW-1:0] TMR_LAST = TW'(TILE_CYCLES - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CROSS = 1'b1;

  localparam logic [2:0] L_FWD   = 3'b001;
  localparam logic [2:0] L_LEFT  = 3'b010;
  localparam logic [2:0] L_RIGHT = 3'b011;
  localparam logic [2:0] L_GO    = 3'b100;

  logic [2:0] light [4];
  assign light[0] = outN;
  assign light[1] = outS;
  assign light[2] = outE;
  assign light[3] = outW;

  logic [1:0]    mem_q  [4][QDEPTH];
  logic [1:0]    mem_d  [4][QDEPTH];
  logic [PW-1:0] wr_q   [4];
  logic [PW-1:0] wr_d   [4];
  logic [PW-1:0] rd_q   [4];
  logic [PW-1:0] rd_d   [4];
  logic [CW-1:0] cnt_q  [4];
  logic [CW-1:0] cnt_d  [4];
  logic [0:0]    st_q   [4];
  logic [0:0]    st_d   [4];
  logic [1:0]    turn_q [4];
  logic [1:0]    turn_d [4];
  logic [1:0]    idx_q  [4];
  logic [1:0]    idx_d  [4];
  logic [TW-1:0] tmr_q  [4];
  logic [TW-1:0] tmr_d  [4];
  logic [7:0]    sensor_q, sensor_d;
  logic [3:0]    exit_q, exit_d;
  logic          coll_q, coll_d;

  logic [3:0]    push, pop, occ;
  logic          coll_now;

  function automatic logic permits(input logic [2:0] code, input logic [1:0] turn);
    logic ok;
    ok = 1'b0;
    case (code)
      L_GO:    ok = 1'b1;
      L_FWD:   ok = (turn == 2'b00) || (turn == 2'b11);
      L_LEFT:  ok = (turn == 2'b01);
      L_RIGHT: ok = (turn == 2'b10);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Index of the final tile: right crosses 1 tile, forward 2, left 3.
  function automatic logic [1:0] last_idx(input logic [1:0] turn);
    logic [1:0] li;
    case (turn)
      2'b01:   li = 2'd2;
      2'b10:   li = 2'd0;
      default: li = 2'd1;
    endcase
    return li;
  endfunction

  // Each approach's forward and right paths are prefixes of its left path,
  // so one 3-tile sequence per approach covers all turns (idx 0 in the low bits).
  function automatic logic [1:0] path_tile(input logic [1:0] dir, input logic [1:0] idx);
    logic [5:0] seq;
    logic [1:0] t;
    case (dir)
      2'd0:    seq = {2'd0, 2'd1, 2'd3};
      2'd1:    seq = {2'd3, 2'd2, 2'd0};
      2'd2:    seq = {2'd1, 2'd3, 2'd2};
      default: seq = {2'd2, 2'd0, 2'd1};
    endcase
    case (idx)
      2'd0:    t = seq[1:0];
      2'd1:    t = seq[3:2];
      default: t = seq[5:4];
    endcase
    return t;
  endfunction

  always_comb begin
    arr.arr_ready = '0;
    for (int d = 0; d < 4; d++) begin
      arr.arr_ready[d] = (cnt_q[d] != CNT_FULL);
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    st_d     = st_q;
    turn_d   = turn_q;
    idx_d    = idx_q;
    tmr_d    = tmr_q;
    exit_d   = '0;
    push     = '0;
    pop      = '0;
    occ      = '0;
    coll_now = 1'b0;
    sensor_d = '0;

    for (int d = 0; d < 4; d++) begin
      push[d] = arr.arr_valid[d] && (cnt_q[d] != CNT_FULL);
      // Entry decision uses the slot state of the current cycle, so a head car
      // can only follow an exiting car one edge after the exit.
      pop[d]  = (cnt_q[d] != '0) && (st_q[d] == S_IDLE) &&
                permits(light[d], mem_q[d][rd_q[d]]);

      if (push[d]) begin
        mem_d[d][wr_q[d]] = arr.arr_turn[2*d +: 2];
        wr_d[d]           = wr_q[d] + 1'b1;
      end
      if (pop[d]) begin
        rd_d[d] = rd_q[d] + 1'b1;
      end
      case ({push[d], pop[d]})
        2'b10:   cnt_d[d] = cnt_q[d] + 1'b1;
        2'b01:   cnt_d[d] = cnt_q[d] - 1'b1;
        default: cnt_d[d] = cnt_q[d];
      endcase

      if (st_q[d] == S_CROSS) begin
        if (tmr_q[d] == TMR_LAST) begin
          tmr_d[d] = '0;
          if (idx_q[d] == last_idx(turn_q[d])) begin
            st_d[d]   = S_IDLE;
            exit_d[d] = 1'b1;
          end else begin
            idx_d[d] = idx_q[d] + 1'b1;
          end
        end else begin
          tmr_d[d] = tmr_q[d] + 1'b1;
        end
      end else if (pop[d]) begin
        st_d[d]   = S_CROSS;
        turn_d[d] = mem_q[d][rd_q[d]];
        idx_d[d]  = 2'd0;
        tmr_d[d]  = '0;
      end
    end

    // Occupancy and collision reflect the slot state being registered this edge.
    for (int d = 0; d < 4; d++) begin
      if (st_d[d] == S_CROSS) begin
        if (occ[path_tile(2'(d), idx_d[d])]) begin
          coll_now = 1'b1;
        end
        occ[path_tile(2'(d), idx_d[d])] = 1'b1;
      end
    end

    sensor_d[3:0] = occ;
    sensor_d[6]   = (cnt_d[0] != '0);
    sensor_d[4]   = (cnt_d[1] != '0);
    sensor_d[5]   = (cnt_d[2] != '0);
    sensor_d[7]   = (cnt_d[3] != '0);
    coll_d        = coll_q | coll_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < 4; d++) begin
        wr_q[d]   <= '0;
        rd_q[d]   <= '0;
        cnt_q[d]  <= '0;
        st_q[d]   <= S_IDLE;
        turn_q[d] <= '0;
        idx_q[d]  <= '0;
        tmr_q[d]  <= '0;
      end
      sensor_q <= '0;
      exit_q   <= '0;
      coll_q   <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      st_q     <= st_d;
      turn_q   <= turn_d;
      idx_q    <= idx_d;
      tmr_q    <= tmr_d;
      sensor_q <= sensor_d;
      exit_q   <= exit_d;
      coll_q   <= coll_d;
    end
  end

  // FIFO storage needs no reset: entries are only read when the count says they are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign sensor_light = sensor_q;
  assign exit_pulse   = exit_q;
  assign collision    = coll_q;

endmodule

// File: tb/tb_intersection_model.sv
// tb/tb_intersection_model.sv - directed bench for intersection_model with an exit-event scoreboard
// Purpose: drives directed car/light sequences; expected exits (approach, cycle) are queued when
//   cars are released and checked when exit_pulse fires; sensor/ready/collision checked inline.
module tb_intersection_model;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] outN, outS, outE, outW;
  logic [7:0] sensor_light;
  logic [3:0] exit_pulse;
  logic       collision;

  intersection_model_if arr ();

  intersection_model #(.QDEPTH(4), .TILE_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .outN         (outN),
    .outS         (outS),
    .outE         (outE),
    .outW         (outW),
    .arr          (arr),
    .sensor_light (sensor_light),
    .exit_pulse   (exit_pulse),
    .collision    (collision)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int d;
    int at;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Exit scoreboard: every exit_pulse bit must match the next expected (approach, edge).
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (exit_pulse[d] === 1'b1) begin
        if (sb.size() == 0) begin
          chk("exit_unexpected", {28'b0, exit_pulse}, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("exit_dir", d, e.d);
          chk("exit_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin
    int k;
    int m;

    // 1: reset with arbitrary inputs
    rst = 1'b1;
    outN = 3'($urandom); outS = 3'($urandom); outE = 3'($urandom); outW = 3'($urandom);
    arr.arr_valid = 4'($urandom);
    arr.arr_turn  = 8'($urandom);
    tick(2);
    chk("rst_sensor", {24'b0, sensor_light}, 32'h0);
    chk("rst_exit", {28'b0, exit_pulse}, 32'h0);
    chk("rst_coll", {31'b0, collision}, 32'h0);
    chk("rst_ready", {28'b0, arr.arr_ready}, 32'hF);
    rst = 1'b0;
    outN = 3'b000; outS = 3'b000; outE = 3'b000; outW = 3'b000;
    arr.arr_valid = 4'b0;
    arr.arr_turn  = 8'h00;
    tick(1);
    chk("idle_sensor", {24'b0, sensor_light}, 32'h0);

    // 2: S forward under Go: wait 1 cycle, tile 0 x2, tile 2 x2, exit
    outS = 3'b100;
    arr.arr_valid = 4'b0010;
    arr.arr_turn  = 8'h00;
    k = cyc;
    sb.push_back(exp_t'{d: 1, at: k + 6});
    tick(1);
    arr.arr_valid = 4'b0;
    chk("t2_wait", {24'b0, sensor_light}, 32'h10);
    tick(1); chk("t2_tile0a", {24'b0, sensor_light}, 32'h01);
    tick(1); chk("t2_tile0b", {24'b0, sensor_light}, 32'h01);
    tick(1); chk("t2_tile2a", {24'b0, sensor_light}, 32'h04);
    tick(1); chk("t2_tile2b", {24'b0, sensor_light}, 32'h04);
    tick(1);
    chk("t2_exit", {28'b0, exit_pulse}, 32'h2);
    chk("t2_clear", {24'b0, sensor_light}, 32'h0);
    tick(1);
    chk("t2_exit_once", {28'b0, exit_pulse}, 32'h0);
    outS = 3'b000;

    // 3: N left held by Forward_only, released by Left_only
    outN = 3'b001;
    arr.arr_valid = 4'b0001;
    arr.arr_turn  = 8'b0000_0001;
    tick(1);
    arr.arr_valid = 4'b0;
    chk("t3_wait", {24'b0, sensor_light}, 32'h40);
    tick(10);
    chk("t3_held", {24'b0, sensor_light}, 32'h40);
    chk("t3_noexit", {28'b0, exit_pulse}, 32'h0);
    outN = 3'b010;
    m = cyc;
    sb.push_back(exp_t'{d: 0, at: m + 7});
    tick(1); chk("t3_tile3", {24'b0, sensor_light}, 32'h08);
    tick(2); chk("t3_tile1", {24'b0, sensor_light}, 32'h02);
    tick(2); chk("t3_tile0", {24'b0, sensor_light}, 32'h01);
    tick(2);
    chk("t3_exit", {28'b0, exit_pulse}, 32'h1);
    chk("t3_clear", {24'b0, sensor_light}, 32'h0);
    outN = 3'b000;

    // 4: fill E FIFO under Stop, then drain under Go
    arr.arr_turn  = 8'h00;
    arr.arr_valid = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("t4_ready_fill", {31'b0, arr.arr_ready[2]}, (i < 3) ? 32'h1 : 32'h0);
    end
    tick(2);
    chk("t4_fifth_held", {28'b0, arr.arr_ready}, 32'hB);
    chk("t4_wait", {24'b0, sensor_light}, 32'h20);
    arr.arr_valid = 4'b0;
    outE = 3'b100;
    m = cyc;
    for (int i = 0; i < 4; i++) sb.push_back(exp_t'{d: 2, at: m + 5 + 5 * i});
    tick(2);
    chk("t4_ready_back", {28'b0, arr.arr_ready}, 32'hF);
    tick(20);
    chk("t4_drained", {24'b0, sensor_light}, 32'h0);
    chk("t4_sb_empty", sb.size(), 32'h0);
    chk("t4_no_coll", {31'b0, collision}, 32'h0);
    outE = 3'b000;

    // 5: N fwd and W right meet on tile 1
    outN = 3'b100;
    outW = 3'b000;
    arr.arr_turn  = 8'b1000_0000;
    arr.arr_valid = 4'b1001;
    k = cyc;
    tick(1);
    arr.arr_valid = 4'b0;
    chk("t5_waits", {24'b0, sensor_light}, 32'hC0);
    tick(1); chk("t5_n_tile3", {24'b0, sensor_light}, 32'h88);
    tick(1); chk("t5_n_tile3b", {24'b0, sensor_light}, 32'h88);
    chk("t5_no_coll_yet", {31'b0, collision}, 32'h0);
    outW = 3'b100;
    sb.push_back(exp_t'{d: 0, at: k + 6});
    sb.push_back(exp_t'{d: 3, at: k + 6});
    tick(1);
    chk("t5_shared", {24'b0, sensor_light}, 32'h02);
    chk("t5_coll", {31'b0, collision}, 32'h1);
    tick(2);
    chk("t5_exit", {28'b0, exit_pulse}, 32'h9);
    chk("t5_clear", {24'b0, sensor_light}, 32'h0);
    tick(5);
    chk("t5_coll_sticky", {31'b0, collision}, 32'h1);
    outN = 3'b000;
    outW = 3'b000;

    // 6: reset with 2 cars in flight and 3 queued
    outN = 3'b100;
    outS = 3'b100;
    arr.arr_turn  = 8'h00;
    arr.arr_valid = 4'b0111;
    tick(1);
    arr.arr_valid = 4'b0011;
    tick(1);
    arr.arr_valid = 4'b0;
    chk("t6_busy", {24'b0, sensor_light}, 32'h79);
    rst = 1'b1;
    tick(1);
    chk("t6_rst_sensor", {24'b0, sensor_light}, 32'h0);
    chk("t6_rst_exit", {28'b0, exit_pulse}, 32'h0);
    chk("t6_rst_coll", {31'b0, collision}, 32'h0);
    chk("t6_rst_ready", {28'b0, arr.arr_ready}, 32'hF);
    rst = 1'b0;
    tick(12);
    chk("t6_quiet", {24'b0, sensor_light}, 32'h0);
    chk("sb_empty", sb.size(), 32'h0);
    outN = 3'b000;
    outS = 3'b000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
